t05_huff_node_builder: RTL



---
 rtl/t05_huff_node_builder_pkg.sv | 42 ++++
 rtl/t05_huff_node_builder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/t05_huff_node_builder_pkg.sv
// ---------------------------------------------------------------------------
// t05_huff_pkg
// Shared types and constants for the Huffman node builder.
//
// Contents:
//   NODE_W / SUM_W        index and frequency widths
//   MAX_NODES             internal node capacity (node table depth)
//   NODE_IDX_W            width of a node table address
//   LEAF_CNT / INT_BASE   leaf alphabet size and the frequency-table base of
//                         internal nodes (internal node n lives at INT_BASE+n)
//   node_idx_t            9-bit tree index, bit 8 set = internal node
//   node_t                node table entry {left, right, sum}
//   state_t               builder FSM states
// ---------------------------------------------------------------------------
package t05_huff_pkg;

    localparam int NODE_W     = 9;
    localparam int SUM_W      = 64;
    localparam int MAX_NODES  = 128;
    localparam int NODE_IDX_W = $clog2(MAX_NODES);
    localparam int LEAF_CNT   = 256;
    localparam int INT_BASE   = 256;

    typedef logic [NODE_W-1:0] node_idx_t;

    typedef struct packed {
        node_idx_t          left;
        node_idx_t          right;
        logic [SUM_W-1:0]   sum;
    } node_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WIPE1,
        ST_WIPE2,
        ST_NODE,
        ST_SUMW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/t05_huff_node_builder.sv
// ---------------------------------------------------------------------------
// t05_huff_node_builder
// Consumes the two least-frequency entries reported by the finder on each
// scan pass, retires them from the frequency table, records a new internal
// node and writes that node's sum back into the frequency table so the next
// pass can pick it up. After leaf_count-1 merges it reports the tree root.
//
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   start, leaf_count          begin a build with this many live leaves
//   least1, least2, sum_in     finder result, valid with fin_in
//   fin_in                     finder pass-complete pulse
//   find_en                    finder enable
//   freq_wr_en/addr/data/ack   frequency table write port (req/ack)
//   node_wr_en/addr/data/ack   node table write port (req/ack)
//   tree_done, root            build finished, root index
//   err                        sticky error flag
//
// Build option:
//   T05_PAIR_CHECK_EN  when defined, every finder result is sanity checked
//                      before any write; a bad pair aborts the build with err.
// ---------------------------------------------------------------------------
import t05_huff_pkg::*;

module t05_huff_node_builder (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            start,
    input  logic [NODE_W-1:0]               leaf_count,
    input  logic [NODE_W-1:0]               least1,
    input  logic [NODE_W-1:0]               least2,
    input  logic [SUM_W-1:0]                sum_in,
    input  logic                            fin_in,
    output logic                            find_en,
    output logic                            freq_wr_en,
    output logic [NODE_W-1:0]               freq_wr_addr,
    output logic [SUM_W-1:0]                freq_wr_data,
    input  logic                            freq_ack,
    output logic                            node_wr_en,
    output logic [NODE_IDX_W-1:0]           node_wr_addr,
    output logic [2*NODE_W+SUM_W-1:0]       node_wr_data,
    input  logic                            node_ack,
    output logic                            tree_done,
    output logic [NODE_W-1:0]               root,
    output logic                            err
);

    // Largest leaf count the node table can absorb: n leaves need n-1 nodes.
    localparam node_idx_t LC_LIMIT = node_idx_t'(MAX_NODES + 1);

    state_t                 state;
    node_idx_t              lc_q;
    node_idx_t              l1_q;
    node_idx_t              l2_q;
    logic [SUM_W-1:0]       sum_q;
    logic [NODE_IDX_W-1:0]  node_idx;

    node_idx_t              node_ext;
    node_idx_t              int_addr;
    logic                   last_merge;
    node_t                  node_q;

    // Frequency-table slot of the node being built, and the test that tells
    // us this merge is the final one (n leaves produce nodes 0..n-2).
    assign node_ext   = {{(NODE_W-NODE_IDX_W){1'b0}}, node_idx};
    assign int_addr   = node_idx_t'(INT_BASE) | node_ext;
    assign last_merge = (node_ext == (lc_q - node_idx_t'(2)));
    assign node_q     = '{left: l1_q, right: l2_q, sum: sum_q};

`ifdef T05_PAIR_CHECK_EN
    logic pair_bad;

    // A usable pair names two different entries, carries a nonzero sum and
    // only refers to internal nodes that have already been built.
    always_comb begin
        pair_bad = 1'b0;
        if (least1 == least2) begin
            pair_bad = 1'b1;
        end
        if (sum_in == '0) begin
            pair_bad = 1'b1;
        end
        if (least1[NODE_W-1] && (least1[NODE_IDX_W-1:0] >= node_idx)) begin
            pair_bad = 1'b1;
        end
        if (least2[NODE_W-1] && (least2[NODE_IDX_W-1:0] >= node_idx)) begin
            pair_bad = 1'b1;
        end
    end
`endif

    // Single FSM with registered outputs. Each write state raises its request
    // on entry and holds address/data untouched until the ack is sampled, so
    // the memory side sees a clean, stable request regardless of its latency.
    // start is only honoured in IDLE and DONE, so a build cannot be clobbered
    // half way through; a restart from DONE behaves exactly like one from IDLE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            lc_q         <= '0;
            l1_q         <= '0;
            l2_q         <= '0;
            sum_q        <= '0;
            node_idx     <= '0;
            find_en      <= 1'b0;
            freq_wr_en   <= 1'b0;
            freq_wr_addr <= '0;
            freq_wr_data <= '0;
            node_wr_en   <= 1'b0;
            node_wr_addr <= '0;
            node_wr_data <= '0;
            tree_done    <= 1'b0;
            root         <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lc_q      <= leaf_count;
                        node_idx  <= '0;
                        err       <= 1'b0;
                        tree_done <= 1'b0;
                        root      <= '0;
                        if (leaf_count == '0 || leaf_count > LC_LIMIT) begin
                            state     <= ST_DONE;
                            err       <= 1'b1;
                            tree_done <= 1'b1;
                        end else if (leaf_count == node_idx_t'(1)) begin
                            // A lone leaf is its own tree; nothing to merge.
                            state     <= ST_DONE;
                            tree_done <= 1'b1;
                        end else begin
                            state   <= ST_SCAN;
                            find_en <= 1'b1;
                        end
                    end
                end

                ST_SCAN: begin
                    if (fin_in) begin
                        find_en <= 1'b0;
                        l1_q    <= least1;
                        l2_q    <= least2;
                        sum_q   <= sum_in;
`ifdef T05_PAIR_CHECK_EN
                        if (pair_bad) begin
                            state     <= ST_DONE;
                            err       <= 1'b1;
                            tree_done <= 1'b1;
                            root      <= '0;
                        end else begin
                            state        <= ST_WIPE1;
                            freq_wr_en   <= 1'b1;
                            freq_wr_addr <= least1;
                            freq_wr_data <= '0;
                        end
`else
                        state        <= ST_WIPE1;
                        freq_wr_en   <= 1'b1;
                        freq_wr_addr <= least1;
                        freq_wr_data <= '0;
`endif
                    end
                end

                ST_WIPE1: begin
                    if (freq_ack) begin
                        state        <= ST_WIPE2;
                        freq_wr_addr <= l2_q;
                        freq_wr_data <= '0;
                    end
                end

                ST_WIPE2: begin
                    if (freq_ack) begin
                        state        <= ST_NODE;
                        freq_wr_en   <= 1'b0;
                        freq_wr_addr <= '0;
                        node_wr_en   <= 1'b1;
                        node_wr_addr <= node_idx;
                        node_wr_data <= node_q;
                    end
                end

                ST_NODE: begin
                    if (node_ack) begin
                        state        <= ST_SUMW;
                        node_wr_en   <= 1'b0;
                        freq_wr_en   <= 1'b1;
                        freq_wr_addr <= int_addr;
                        freq_wr_data <= sum_q;
                    end
                end

                ST_SUMW: begin
                    if (freq_ack) begin
                        freq_wr_en   <= 1'b0;
                        freq_wr_addr <= '0;
                        freq_wr_data <= '0;
                        if (last_merge) begin
                            state     <= ST_DONE;
                            tree_done <= 1'b1;
                            root      <= int_addr;
                        end else begin
                            state    <= ST_SCAN;
                            node_idx <= node_idx + 1'b1;
                            find_en  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
